// File: rtl/ahb_mtx_in_stg_hold.sv
// AHB bus-matrix input stage: holds a stalled address phase and replays it until granted.
// Optional user-signal sideband is enabled by defining AHB_MTX_IN_STG_XUSER_EN.
module ahb_mtx_in_stg_hold #(
    parameter int          ADDR_W    = 32,
    parameter int          USER_W    = 32,
    parameter logic [3:0]  MASTER_ID = 4'b0000
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSELS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [3:0]        HPROTS,
    input  logic              HMASTLOCKS,
    input  logic [USER_W-1:0] HAUSERS,
    input  logic [USER_W-1:0] HWUSERS,
    input  logic [31:0]       HWDATAS,
    input  logic              HREADYS,
    input  logic              active_ip,
    input  logic              readyout_ip,
    input  logic [1:0]        resp_ip,
    output logic              sel_ip,
    output logic [ADDR_W-1:0] addr_ip,
    output logic [USER_W-1:0] auser_ip,
    output logic [1:0]        trans_ip,
    output logic              write_ip,
    output logic [2:0]        size_ip,
    output logic [2:0]        burst_ip,
    output logic [3:0]        prot_ip,
    output logic              mastlock_ip,
    output logic [3:0]        master_ip,
    output logic [31:0]       wdata_ip,
    output logic [USER_W-1:0] wuser_ip,
    output logic              held_tran_ip,
    output logic              HREADYOUTS,
    output logic [1:0]        HRESPS
);

    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_ERROR   = 2'b01;

    logic              pend_tran;
    logic              data_ph;
    logic              new_tran;
    logic              granted;
    logic              err_cancel;

    logic              h_sel;
    logic [ADDR_W-1:0] h_addr;
    logic [1:0]        h_trans;
    logic              h_write;
    logic [2:0]        h_size;
    logic [2:0]        h_burst;
    logic [3:0]        h_prot;
    logic              h_lock;

    assign new_tran   = HSELS & HTRANSS[1] & HREADYS;
    assign granted    = active_ip & readyout_ip;
    // First ERROR cycle from the previous data phase drops the held transfer.
    assign err_cancel = pend_tran & (resp_ip == RESP_ERROR) & ~readyout_ip;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pend_tran <= 1'b0;
            data_ph   <= 1'b0;
            h_sel     <= 1'b0;
            h_addr    <= '0;
            h_trans   <= '0;
            h_write   <= 1'b0;
            h_size    <= '0;
            h_burst   <= '0;
            h_prot    <= '0;
            h_lock    <= 1'b0;
        end else begin
            if (HREADYS) begin
                h_sel   <= HSELS;
                h_addr  <= HADDRS;
                h_trans <= HTRANSS;
                h_write <= HWRITES;
                h_size  <= HSIZES;
                h_burst <= HBURSTS;
                h_prot  <= HPROTS;
                h_lock  <= HMASTLOCKS;
            end

            if (granted) begin
                pend_tran <= 1'b0;
            end else if (err_cancel) begin
                pend_tran <= 1'b0;
            end else if (new_tran) begin
                pend_tran <= 1'b1;
            end

            if (held_tran_ip && granted) begin
                data_ph <= 1'b1;
            end else if (readyout_ip) begin
                data_ph <= 1'b0;
            end
        end
    end

`ifdef AHB_MTX_IN_STG_XUSER_EN
    logic [USER_W-1:0] h_auser;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            h_auser <= '0;
        end else if (HREADYS) begin
            h_auser <= HAUSERS;
        end
    end

    assign auser_ip = pend_tran ? h_auser : HAUSERS;
    assign wuser_ip = HWUSERS;
`else
    logic unused_user;

    assign unused_user = ^{HAUSERS, HWUSERS};
    assign auser_ip    = '0;
    assign wuser_ip    = '0;
`endif

    always_comb begin
        sel_ip      = HSELS;
        addr_ip     = HADDRS;
        trans_ip    = HTRANSS;
        write_ip    = HWRITES;
        size_ip     = HSIZES;
        burst_ip    = HBURSTS;
        prot_ip     = HPROTS;
        mastlock_ip = HMASTLOCKS;
        if (pend_tran) begin
            sel_ip      = h_sel;
            addr_ip     = h_addr;
            // A replayed beat loses its burst context downstream, so SEQ restarts as NONSEQ.
            trans_ip    = (h_trans == TRANS_SEQ) ? TRANS_NONSEQ : h_trans;
            write_ip    = h_write;
            size_ip     = h_size;
            burst_ip    = h_burst;
            prot_ip     = h_prot;
            mastlock_ip = h_lock;
        end
    end

    assign master_ip    = MASTER_ID;
    assign wdata_ip     = HWDATAS;
    assign held_tran_ip = pend_tran | new_tran;

    always_comb begin
        HREADYOUTS = 1'b1;
        if (pend_tran) begin
            HREADYOUTS = 1'b0;
        end else if (data_ph) begin
            HREADYOUTS = readyout_ip;
        end
    end

    assign HRESPS = data_ph ? resp_ip : RESP_OKAY;

endmodule

// File: tb/tb_ahb_mtx_in_stg_hold.sv
// Scoreboard bench for ahb_mtx_in_stg_hold: per-cycle expectations from a transfer-level model.
module tb_ahb_mtx_in_stg_hold;

    typedef struct {
        bit        rst;
        bit        sel;
        bit [31:0] addr;
        bit [1:0]  trans;
        bit        write;
        bit [2:0]  size;
        bit [2:0]  burst;
        bit [3:0]  prot;
        bit        lock;
        bit [31:0] auser;
        bit [31:0] wuser;
        bit [31:0] wdata;
        bit        hready;
        bit        active;
        bit        readyout;
        bit [1:0]  resp;
    } stim_t;

    typedef struct {
        bit        sel;
        bit [31:0] addr;
        bit [31:0] auser;
        bit [1:0]  trans;
        bit        write;
        bit [2:0]  size;
        bit [2:0]  burst;
        bit [3:0]  prot;
        bit        lock;
        bit [3:0]  master;
        bit [31:0] wdata;
        bit [31:0] wuser;
        bit        held;
        bit        hreadyout;
        bit [1:0]  hresp;
    } exp_t;

    localparam logic [3:0] MID = 4'b0101;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic [31:0] hauser;
    logic [31:0] hwuser;
    logic [31:0] hwdata;
    logic        hready;
    logic        active;
    logic        readyout;
    logic [1:0]  resp;

    logic        sel_o;
    logic [31:0] addr_o;
    logic [31:0] auser_o;
    logic [1:0]  trans_o;
    logic        write_o;
    logic [2:0]  size_o;
    logic [2:0]  burst_o;
    logic [3:0]  prot_o;
    logic        lock_o;
    logic [3:0]  master_o;
    logic [31:0] wdata_o;
    logic [31:0] wuser_o;
    logic        held_o;
    logic        hreadyout;
    logic [1:0]  hresp;

    int unsigned tests = 0;
    int unsigned fails = 0;

    exp_t exp_q[$];

    // Model state: is a stalled transfer waiting, is this port in a data phase, last captured address phase.
    bit    waiting = 1'b0;
    bit    in_data = 1'b0;
    stim_t last_addr;

    ahb_mtx_in_stg_hold #(
        .ADDR_W    (32),
        .USER_W    (32),
        .MASTER_ID (MID)
    ) dut (
        .HCLK         (clk),
        .HRESET       (rst),
        .HSELS        (hsel),
        .HADDRS       (haddr),
        .HTRANSS      (htrans),
        .HWRITES      (hwrite),
        .HSIZES       (hsize),
        .HBURSTS      (hburst),
        .HPROTS       (hprot),
        .HMASTLOCKS   (hmastlock),
        .HAUSERS      (hauser),
        .HWUSERS      (hwuser),
        .HWDATAS      (hwdata),
        .HREADYS      (hready),
        .active_ip    (active),
        .readyout_ip  (readyout),
        .resp_ip      (resp),
        .sel_ip       (sel_o),
        .addr_ip      (addr_o),
        .auser_ip     (auser_o),
        .trans_ip     (trans_o),
        .write_ip     (write_o),
        .size_ip      (size_o),
        .burst_ip     (burst_o),
        .prot_ip      (prot_o),
        .mastlock_ip  (lock_o),
        .master_ip    (master_o),
        .wdata_ip     (wdata_o),
        .wuser_ip     (wuser_o),
        .held_tran_ip (held_o),
        .HREADYOUTS   (hreadyout),
        .HRESPS       (hresp)
    );

    always #5 clk = ~clk;

    function automatic stim_t idle_stim();
        stim_t s;
        s = '{default: '0};
        s.hready   = 1'b1;
        s.readyout = 1'b1;
        return s;
    endfunction

    function automatic exp_t predict(stim_t s);
        exp_t  e;
        stim_t src;
        bit    starts;
        starts = s.sel && (s.trans == 2'b10 || s.trans == 2'b11) && s.hready;
        src    = waiting ? last_addr : s;
        e.sel    = src.sel;
        e.addr   = src.addr;
        e.trans  = (waiting && src.trans == 2'b11) ? 2'b10 : src.trans;
        e.write  = src.write;
        e.size   = src.size;
        e.burst  = src.burst;
        e.prot   = src.prot;
        e.lock   = src.lock;
`ifdef AHB_MTX_IN_STG_XUSER_EN
        e.auser  = src.auser;
        e.wuser  = s.wuser;
`else
        e.auser  = 32'h0;
        e.wuser  = 32'h0;
`endif
        e.master = MID;
        e.wdata  = s.wdata;
        e.held   = waiting || starts;
        if (waiting)      e.hreadyout = 1'b0;
        else if (in_data) e.hreadyout = s.readyout;
        else              e.hreadyout = 1'b1;
        e.hresp  = in_data ? s.resp : 2'b00;
        return e;
    endfunction

    task automatic advance_model(stim_t s);
        bit starts;
        bit requesting;
        bit taken;
        starts     = s.sel && (s.trans == 2'b10 || s.trans == 2'b11) && s.hready;
        requesting = waiting || starts;
        taken      = s.active && s.readyout;
        if (s.rst) begin
            waiting   = 1'b0;
            in_data   = 1'b0;
            last_addr = '{default: '0};
        end else begin
            if (requesting && taken)  in_data = 1'b1;
            else if (s.readyout)      in_data = 1'b0;
            if (taken)                                            waiting = 1'b0;
            else if (waiting && s.resp == 2'b01 && !s.readyout)  waiting = 1'b0;
            else if (starts)                                      waiting = 1'b1;
            if (s.hready) last_addr = s;
        end
    endtask

    task automatic step(stim_t s);
        @(posedge clk);
        #1;
        rst       = s.rst;
        hsel      = s.sel;
        haddr     = s.addr;
        htrans    = s.trans;
        hwrite    = s.write;
        hsize     = s.size;
        hburst    = s.burst;
        hprot     = s.prot;
        hmastlock = s.lock;
        hauser    = s.auser;
        hwuser    = s.wuser;
        hwdata    = s.wdata;
        hready    = s.hready;
        active    = s.active;
        readyout  = s.readyout;
        resp      = s.resp;
        exp_q.push_back(predict(s));
        advance_model(s);
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sel_ip",       32'(sel_o),     32'(e.sel));
                check("addr_ip",      addr_o,         e.addr);
                check("auser_ip",     auser_o,        e.auser);
                check("trans_ip",     32'(trans_o),   32'(e.trans));
                check("write_ip",     32'(write_o),   32'(e.write));
                check("size_ip",      32'(size_o),    32'(e.size));
                check("burst_ip",     32'(burst_o),   32'(e.burst));
                check("prot_ip",      32'(prot_o),    32'(e.prot));
                check("mastlock_ip",  32'(lock_o),    32'(e.lock));
                check("master_ip",    32'(master_o),  32'(e.master));
                check("wdata_ip",     wdata_o,        e.wdata);
                check("wuser_ip",     wuser_o,        e.wuser);
                check("held_tran_ip", 32'(held_o),    32'(e.held));
                check("HREADYOUTS",   32'(hreadyout), 32'(e.hreadyout));
                check("HRESPS",       32'(hresp),     32'(e.hresp));
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        last_addr = '{default: '0};
        s = idle_stim();
        rst = 1'b1; hsel = 1'b0; haddr = '0; htrans = '0; hwrite = 1'b0;
        hsize = '0; hburst = '0; hprot = '0; hmastlock = 1'b0;
        hauser = '0; hwuser = '0; hwdata = '0;
        hready = 1'b1; active = 1'b0; readyout = 1'b1; resp = '0;
        repeat (2) @(posedge clk);

        step(s);
        // Granted NONSEQ read
        s.sel = 1'b1; s.trans = 2'b10; s.addr = 32'h2000_0010; s.active = 1'b1;
        step(s);
        // Stalled NONSEQ with user bits, then three stall cycles with changing address
        s.active = 1'b0; s.auser = 32'hA5; s.wuser = 32'h5A; s.write = 1'b1; s.prot = 4'h3;
        step(s);
        for (int i = 0; i < 3; i++) begin
            s.hready = 1'b0;
            s.addr   = $urandom;
            s.auser  = $urandom;
            s.wdata  = $urandom;
            step(s);
        end
        s.active = 1'b1;
        step(s);
        // Held SEQ beat
        s.hready = 1'b1; s.trans = 2'b11; s.addr = 32'h2000_0014; s.active = 1'b0;
        step(s);
        s.hready = 1'b0; s.addr = 32'h0;
        step(s);
        step(s);
        s.active = 1'b1;
        step(s);
        // Capture a new transfer during an unfinished data phase, then ERROR cancels it
        s.hready = 1'b1; s.trans = 2'b10; s.addr = 32'h3000_0000; s.active = 1'b0; s.readyout = 1'b0;
        step(s);
        s.hready = 1'b0; s.resp = 2'b01;
        step(s);
        s.hready = 1'b1; s.readyout = 1'b1; s.sel = 1'b0; s.trans = 2'b00;
        step(s);
        s.resp = 2'b00;
        step(s);
        // Reset while stalled
        s.sel = 1'b1; s.trans = 2'b10; s.addr = 32'h4000_0040;
        step(s);
        s.hready = 1'b0;
        step(s);
        s.rst = 1'b1;
        step(s);
        s.rst = 1'b0; s.hready = 1'b1; s.trans = 2'b00;
        step(s);

        for (int i = 0; i < 600; i++) begin
            s.rst      = ($urandom_range(0, 49) == 0);
            s.sel      = ($urandom_range(0, 3) != 0);
            s.addr     = $urandom;
            s.trans    = 2'($urandom_range(0, 3));
            s.write    = 1'($urandom);
            s.size     = 3'($urandom);
            s.burst    = 3'($urandom);
            s.prot     = 4'($urandom);
            s.lock     = 1'($urandom);
            s.auser    = $urandom;
            s.wuser    = $urandom;
            s.wdata    = $urandom;
            s.hready   = ($urandom_range(0, 3) != 0);
            s.active   = 1'($urandom);
            s.readyout = ($urandom_range(0, 3) != 0);
            s.resp     = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00;
            step(s);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
